// File: rtl/window_comparator_pkg.sv
// ----------------------------------------------------------------------------
// window_comparator_pkg
//   Shared types and helpers for the window comparator.
//   - zone_t  : confirmed/raw zone encoding (BELOW 00, INSIDE 01, ABOVE 10)
//   - state_t : filter FSM states (INIT plus one state per zone)
//   - min/max helpers for signed and unsigned ranges of a given width
//   - classify / zone_to_state helpers
// ----------------------------------------------------------------------------
package window_comparator_pkg;

  localparam int DATA_WIDTH_DEF = 13;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ZONE_BELOW  = 2'b00,
    ZONE_INSIDE = 2'b01,
    ZONE_ABOVE  = 2'b10
  } zone_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_BELOW,
    ST_INSIDE,
    ST_ABOVE
  } state_t;

  // Range limits for a 'width'-bit value in each compare mode.
  function automatic longint unsigned_max(input int width);
    return (longint'(1) << width) - 1;
  endfunction

  function automatic longint signed_max(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint signed_min(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

  // BELOW wins over ABOVE, which only matters when thresholds are inverted.
  function automatic zone_t classify(input logic below, input logic above);
    if (below)      return ZONE_BELOW;
    else if (above) return ZONE_ABOVE;
    else            return ZONE_INSIDE;
  endfunction

  function automatic state_t zone_to_state(input zone_t z);
    case (z)
      ZONE_BELOW: return ST_BELOW;
      ZONE_ABOVE: return ST_ABOVE;
      default:    return ST_INSIDE;
    endcase
  endfunction

endpackage

// File: rtl/window_comparator_fsm_magnitude_compare_sgn.sv
// ----------------------------------------------------------------------------
// magnitude_compare_sgn
//   Combinational a<b / a>b in either two's-complement or unsigned mode.
//   Ports:
//     a_i, b_i       operands (WIDTH bits)
//     signed_mode_i  1 = two's-complement compare, 0 = unsigned
//     lt_o, gt_o     a < b, a > b
// ----------------------------------------------------------------------------
module magnitude_compare_sgn #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  output logic             lt_o,
  output logic             gt_o
);

  always_comb begin
    if (signed_mode_i) begin
      lt_o = $signed(a_i) < $signed(b_i);
      gt_o = $signed(a_i) > $signed(b_i);
    end else begin
      lt_o = a_i < b_i;
      gt_o = a_i > b_i;
    end
  end

endmodule

// File: rtl/window_comparator_fsm.sv
// ----------------------------------------------------------------------------
// window_comparator_fsm
//   Two-stage window comparator with a persistence filter.
//   Stage 1 registers the raw below/above flags of each valid sample;
//   stage 2 confirms a zone change only after persist_i consecutive samples
//   agree on the same new zone (0 behaves as 1).
//
//   Ports:
//     clk_i, rst_i          clock, asynchronous active-high reset
//     enable_i              low forces INIT and ignores samples
//     signed_mode_i         1 = two's-complement, 0 = unsigned compares
//     thr_low_i/thr_high_i  window thresholds
//     persist_i             consecutive samples needed to confirm a change
//     sample_i/_valid_i     input sample and qualifier
//     hyst_i                hysteresis (only with WINDOW_COMPARATOR_HYST_EN)
//     below_raw_o           registered sample < thr_low
//     above_raw_o           registered sample > thr_high
//     zone_o                confirmed zone (00 BELOW, 01 INSIDE, 10 ABOVE)
//     zone_valid_o          zone_o is meaningful
//     zone_change_o         one-cycle pulse on every zone_o update
//     thr_error_o           registered thr_low > thr_high
//
//   Optional macro WINDOW_COMPARATOR_HYST_EN adds hyst_i: leaving ABOVE needs
//   sample <= thr_high - hyst, leaving BELOW needs sample >= thr_low + hyst.
// ----------------------------------------------------------------------------
module window_comparator_fsm
  import window_comparator_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  signed_mode_i,
  input  logic [DATA_WIDTH-1:0] thr_low_i,
  input  logic [DATA_WIDTH-1:0] thr_high_i,
  input  logic [CNT_WIDTH-1:0]  persist_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
`ifdef WINDOW_COMPARATOR_HYST_EN
  input  logic [DATA_WIDTH-1:0] hyst_i,
`endif
  output logic                  below_raw_o,
  output logic                  above_raw_o,
  output logic [1:0]            zone_o,
  output logic                  zone_valid_o,
  output logic                  zone_change_o,
  output logic                  thr_error_o
);

  // ---------------------------------------------------------------- stage 1
  logic below_c, above_c, low_gt, high_lt;
  logic thr_err_c;
  logic s1_valid_q;
  logic below_keep, above_keep;  // flags that hold the current outer zone
  logic unused_cmp;

  magnitude_compare_sgn #(.WIDTH(DATA_WIDTH)) u_cmp_low (
    .a_i           (sample_i),
    .b_i           (thr_low_i),
    .signed_mode_i (signed_mode_i),
    .lt_o          (below_c),
    .gt_o          (low_gt)
  );

  magnitude_compare_sgn #(.WIDTH(DATA_WIDTH)) u_cmp_high (
    .a_i           (sample_i),
    .b_i           (thr_high_i),
    .signed_mode_i (signed_mode_i),
    .lt_o          (high_lt),
    .gt_o          (above_c)
  );

  assign unused_cmp = low_gt ^ high_lt;

  assign thr_err_c = signed_mode_i ? ($signed(thr_low_i) > $signed(thr_high_i))
                                   : (thr_low_i > thr_high_i);

`ifdef WINDOW_COMPARATOR_HYST_EN
  // Two extra bits of headroom so neither mode can wrap before clamping.
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0] U_MAX = DATA_WIDTH'(unsigned_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] S_MAX = DATA_WIDTH'(signed_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] S_MIN = DATA_WIDTH'(signed_min(DATA_WIDTH));

  logic signed [EW-1:0] low_ext, high_ext, hyst_ext, lo_bound, hi_bound;
  logic signed [EW-1:0] low_sum, high_diff;
  logic [DATA_WIDTH-1:0] low_adj, high_adj;
  logic below_keep_c, above_keep_c, hl_gt, hh_lt;
  logic unused_hyst;

  function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [EW-1:0] v,
                                                  input logic signed [EW-1:0] lo,
                                                  input logic signed [EW-1:0] hi);
    logic signed [EW-1:0] r;
    r = (v < lo) ? lo : ((v > hi) ? hi : v);
    return r[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    low_ext   = signed_mode_i ? EW'($signed(thr_low_i))  : EW'({1'b0, thr_low_i});
    high_ext  = signed_mode_i ? EW'($signed(thr_high_i)) : EW'({1'b0, thr_high_i});
    hyst_ext  = EW'({1'b0, hyst_i});
    lo_bound  = signed_mode_i ? EW'($signed(S_MIN)) : '0;
    hi_bound  = signed_mode_i ? EW'($signed(S_MAX)) : EW'({1'b0, U_MAX});
    low_sum   = low_ext + hyst_ext;
    high_diff = high_ext - hyst_ext;
    low_adj   = clamp(low_sum, lo_bound, hi_bound);
    high_adj  = clamp(high_diff, lo_bound, hi_bound);
  end

  magnitude_compare_sgn #(.WIDTH(DATA_WIDTH)) u_cmp_low_hyst (
    .a_i           (sample_i),
    .b_i           (low_adj),
    .signed_mode_i (signed_mode_i),
    .lt_o          (below_keep_c),
    .gt_o          (hl_gt)
  );

  magnitude_compare_sgn #(.WIDTH(DATA_WIDTH)) u_cmp_high_hyst (
    .a_i           (sample_i),
    .b_i           (high_adj),
    .signed_mode_i (signed_mode_i),
    .lt_o          (hh_lt),
    .gt_o          (above_keep_c)
  );

  assign unused_hyst = hl_gt ^ hh_lt;
`else
  // Zero hysteresis: staying in an outer zone uses the plain thresholds.
  assign below_keep = below_raw_o;
  assign above_keep = above_raw_o;
`endif

  // NOTE: registered state is written with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      below_raw_o  <= 1'b0;
      above_raw_o  <= 1'b0;
      thr_error_o  <= 1'b0;
`ifdef WINDOW_COMPARATOR_HYST_EN
      below_keep   <= 1'b0;
      above_keep   <= 1'b0;
`endif
    end else begin
      thr_error_o <= thr_err_c;
      s1_valid_q  <= sample_valid_i & enable_i;
      if (!enable_i) begin
        below_raw_o <= 1'b0;
        above_raw_o <= 1'b0;
`ifdef WINDOW_COMPARATOR_HYST_EN
        below_keep  <= 1'b0;
        above_keep  <= 1'b0;
`endif
      end else if (sample_valid_i) begin
        below_raw_o <= below_c;
        above_raw_o <= above_c;
`ifdef WINDOW_COMPARATOR_HYST_EN
        below_keep  <= below_keep_c;
        above_keep  <= above_keep_c;
`endif
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  state_t                 state_q;
  zone_t                  zone_q, last_cand_q, cand;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_next, persist_eff;

  always_comb begin
    // NOTE: default assigned first so every path drives cand; without it a
    // latch would be inferred.
    cand = classify(below_raw_o, above_raw_o);
    if (state_q == ST_ABOVE && !below_raw_o && above_keep) cand = ZONE_ABOVE;
    if (state_q == ST_BELOW && below_keep)                 cand = ZONE_BELOW;
  end

  assign persist_eff = (persist_i == '0) ? CNT_WIDTH'(1) : persist_i;

  // Same candidate as the previous valid sample extends the run (saturating);
  // a different one starts a new run of length 1.
  assign cnt_next = (cand == last_cand_q)
                  ? ((cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1))
                  : CNT_WIDTH'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_INIT;
      zone_q        <= ZONE_BELOW;
      last_cand_q   <= ZONE_BELOW;
      cnt_q         <= '0;
      zone_valid_o  <= 1'b0;
      zone_change_o <= 1'b0;
    end else if (!enable_i) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      zone_valid_o  <= 1'b0;
      zone_change_o <= 1'b0;
    end else begin
      zone_change_o <= 1'b0;
      if (s1_valid_q) begin
        last_cand_q <= cand;
        case (state_q)
          ST_INIT: begin
            state_q       <= zone_to_state(cand);
            zone_q        <= cand;
            zone_valid_o  <= 1'b1;
            zone_change_o <= 1'b1;
            cnt_q         <= '0;
          end
          default: begin
            if (cand == zone_q) begin
              cnt_q <= '0;
            end else if (cnt_next >= persist_eff) begin
              state_q       <= zone_to_state(cand);
              zone_q        <= cand;
              zone_change_o <= 1'b1;
              cnt_q         <= '0;
            end else begin
              cnt_q <= cnt_next;
            end
          end
        endcase
      end
    end
  end

  assign zone_o = zone_q;

endmodule
